store_merge_unit: RTL and testbench

STORE_MERGE_UNIT -- requirements
Module: store_merge_unit

---
 rtl/mips_pkg.sv | 20 ++
 rtl/store_lane_merge.sv | 23 ++
 rtl/store_merge_unit.sv | 116 +++++++++++
 tb/tb_store_merge_unit.sv | 207 ++++++++++++++++++++
 4 files changed

// File: rtl/mips_pkg.sv
// Shared store-merge definitions: access-size encodings and the FSM state type.
package mips_pkg;

  localparam logic [1:0] SZ_BYTE = 2'b00;
  localparam logic [1:0] SZ_HALF = 2'b01;
  localparam logic [1:0] SZ_WORD = 2'b10;

  typedef enum logic [1:0] {
    StIdle,
    StRd,
    StMerge,
    StWr
  } smu_state_e;

  // Encoding 2'b11 is reserved and behaves as a full word.
  function automatic logic is_word_size(input logic [1:0] size);
    return size[1];
  endfunction

endpackage

// File: rtl/store_lane_merge.sv
// Combinational lane insertion: places a byte or halfword into an existing word (little-endian).
module store_lane_merge
  import mips_pkg::*;
(
  input  logic [31:0] old_word,
  input  logic [31:0] data,
  input  logic [1:0]  size,
  input  logic [1:0]  offset,
  output logic [31:0] merged
);

  always_comb begin
    merged = old_word;
    if (is_word_size(size)) begin
      merged = data;
    end else if (size == SZ_HALF) begin
      merged[{offset[1], 4'b0000} +: 16] = data[15:0];
    end else begin
      merged[{offset, 3'b000} +: 8] = data[7:0];
    end
  end

endmodule

// File: rtl/store_merge_unit.sv
// Read-modify-write store unit merging sub-word stores into 32-bit memory words.
// Define STORE_ALIGN_CHECK_EN to reject misaligned halfword/word stores with a fault pulse.
module store_merge_unit
  import mips_pkg::*;
#(
  parameter int unsigned ADDR_W = 32
) (
  input  logic              clk,
  input  logic              rstb,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [1:0]        req_size,
  input  logic [31:0]       req_wdata,
  output logic [ADDR_W-1:0] mem_addr,
  output logic              mem_rd_en,
  input  logic [31:0]       mem_rdata,
  output logic              mem_wr_en,
  output logic [31:0]       mem_wdata,
  output logic              done,
  output logic              misaligned
);

  smu_state_e  state;
  logic [1:0]  size_q;
  logic [1:0]  offset_q;
  logic [31:0] wdata_q;
  logic [31:0] merged;
  logic        align_fault;
  logic        accept;

  assign accept = req_valid && req_ready && (state == StIdle);

`ifdef STORE_ALIGN_CHECK_EN
  assign align_fault = ((req_size == SZ_HALF) && req_addr[0]) ||
                       (is_word_size(req_size) && (req_addr[1:0] != 2'b00));
`else
  assign align_fault = 1'b0;
`endif

  store_lane_merge u_lane_merge (
    .old_word (mem_rdata),
    .data     (wdata_q),
    .size     (size_q),
    .offset   (offset_q),
    .merged   (merged)
  );

  always_ff @(posedge clk or negedge rstb) begin
    if (!rstb) begin
      state      <= StIdle;
      req_ready  <= 1'b0;
      size_q     <= SZ_BYTE;
      offset_q   <= 2'b00;
      wdata_q    <= 32'h0;
      mem_addr   <= '0;
      mem_rd_en  <= 1'b0;
      mem_wr_en  <= 1'b0;
      mem_wdata  <= 32'h0;
      done       <= 1'b0;
      misaligned <= 1'b0;
    end else begin
      mem_rd_en  <= 1'b0;
      mem_wr_en  <= 1'b0;
      done       <= 1'b0;
      misaligned <= 1'b0;
      unique case (state)
        StIdle: begin
          req_ready <= 1'b1;
          if (accept) begin
            size_q   <= req_size;
            offset_q <= req_addr[1:0];
            wdata_q  <= req_wdata;
            if (align_fault) begin
              // Faulting request is dropped; the unit stays idle and ready.
              misaligned <= 1'b1;
            end else if (is_word_size(req_size)) begin
              state     <= StWr;
              req_ready <= 1'b0;
              mem_addr  <= {req_addr[ADDR_W-1:2], 2'b00};
              mem_wdata <= req_wdata;
              mem_wr_en <= 1'b1;
              done      <= 1'b1;
            end else begin
              state     <= StRd;
              req_ready <= 1'b0;
              mem_addr  <= {req_addr[ADDR_W-1:2], 2'b00};
              mem_rd_en <= 1'b1;
            end
          end
        end
        StRd: begin
          state <= StMerge;
        end
        StMerge: begin
          // mem_rdata is valid this cycle, one cycle after the read strobe.
          state     <= StWr;
          mem_wdata <= merged;
          mem_wr_en <= 1'b1;
          done      <= 1'b1;
        end
        StWr: begin
          state     <= StIdle;
          req_ready <= 1'b1;
          mem_addr  <= '0;
        end
        default: begin
          state     <= StIdle;
          req_ready <= 1'b1;
          mem_addr  <= '0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_store_merge_unit.sv
// Directed bench for store_merge_unit with a one-cycle-latency read memory model.
module tb_store_merge_unit;

  logic        clk;
  logic        rstb;
  logic        req_valid;
  logic        req_ready;
  logic [31:0] req_addr;
  logic [1:0]  req_size;
  logic [31:0] req_wdata;
  logic [31:0] mem_addr;
  logic        mem_rd_en;
  logic [31:0] mem_rdata;
  logic        mem_wr_en;
  logic [31:0] mem_wdata;
  logic        done;
  logic        misaligned;

  int n_vec = 0;
  int n_err = 0;

  store_merge_unit #(.ADDR_W(32)) dut (
    .clk        (clk),
    .rstb       (rstb),
    .req_valid  (req_valid),
    .req_ready  (req_ready),
    .req_addr   (req_addr),
    .req_size   (req_size),
    .req_wdata  (req_wdata),
    .mem_addr   (mem_addr),
    .mem_rd_en  (mem_rd_en),
    .mem_rdata  (mem_rdata),
    .mem_wr_en  (mem_wr_en),
    .mem_wdata  (mem_wdata),
    .done       (done),
    .misaligned (misaligned)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Read data only valid the cycle after the strobe; garbage otherwise.
  always @(posedge clk) mem_rdata <= mem_rd_en ? 32'h11223344 : 32'h0BAD0BAD;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic issue(input logic [31:0] addr, input logic [1:0] size, input logic [31:0] wdata);
    req_valid = 1'b1;
    req_addr  = addr;
    req_size  = size;
    req_wdata = wdata;
  endtask

  // Full store with cycle-by-cycle checks; exp_data is the hand-computed merged word.
  task automatic run_store(input string tag, input logic [31:0] addr, input logic [1:0] size,
                           input logic [31:0] wdata, input logic [31:0] exp_data);
    logic [31:0] waddr;
    waddr = {addr[31:2], 2'b00};
    issue(addr, size, wdata);
    tick();
    req_valid = 1'b0;
    check({tag, " ready+1"}, {31'b0, req_ready}, 32'd0);
    if (size[1]) begin
      check({tag, " rd+1"}, {31'b0, mem_rd_en}, 32'd0);
      check({tag, " wr+1"}, {31'b0, mem_wr_en}, 32'd1);
      check({tag, " done+1"}, {31'b0, done}, 32'd1);
    end else begin
      check({tag, " rd+1"}, {31'b0, mem_rd_en}, 32'd1);
      check({tag, " addr+1"}, mem_addr, waddr);
      check({tag, " wr+1"}, {31'b0, mem_wr_en}, 32'd0);
      tick();
      check({tag, " rd+2"}, {31'b0, mem_rd_en}, 32'd0);
      check({tag, " wr+2"}, {31'b0, mem_wr_en}, 32'd0);
      tick();
      check({tag, " wr+3"}, {31'b0, mem_wr_en}, 32'd1);
      check({tag, " done+3"}, {31'b0, done}, 32'd1);
    end
    check({tag, " wdata"}, mem_wdata, exp_data);
    check({tag, " waddr"}, mem_addr, waddr);
    check({tag, " misal"}, {31'b0, misaligned}, 32'd0);
    tick();
    check({tag, " idle ready"}, {31'b0, req_ready}, 32'd1);
    check({tag, " idle wr"}, {31'b0, mem_wr_en | done}, 32'd0);
    check({tag, " idle addr"}, mem_addr, 32'd0);
  endtask

  task automatic run_misaligned(input string tag, input logic [31:0] addr,
                                input logic [1:0] size, input logic [31:0] wdata);
    issue(addr, size, wdata);
    tick();
    req_valid = 1'b0;
    check({tag, " misal+1"}, {31'b0, misaligned}, 32'd1);
    check({tag, " strobes+1"}, {30'b0, mem_rd_en, mem_wr_en}, 32'd0);
    check({tag, " done+1"}, {31'b0, done}, 32'd0);
    tick();
    check({tag, " misal+2"}, {31'b0, misaligned}, 32'd0);
    check({tag, " strobes+2"}, {30'b0, mem_rd_en, mem_wr_en}, 32'd0);
    check({tag, " ready+2"}, {31'b0, req_ready}, 32'd1);
  endtask

  initial begin
    rstb      = 1'b0;
    req_valid = 1'b0;
    req_addr  = 32'h0;
    req_size  = 2'b00;
    req_wdata = 32'h0;

    repeat (3) @(posedge clk);
    #1;
    check("rst ready", {31'b0, req_ready}, 32'd0);
    check("rst strobes", {28'b0, mem_rd_en, mem_wr_en, done, misaligned}, 32'd0);
    check("rst addr", mem_addr, 32'd0);
    check("rst wdata", mem_wdata, 32'd0);
    @(negedge clk);
    rstb = 1'b1;
    tick();
    check("post-rst ready", {31'b0, req_ready}, 32'd1);

    run_store("byte3", 32'h0000_0103, 2'b00, 32'hFFFF_FFAB, 32'hAB22_3344);
    run_store("half1", 32'h0000_0202, 2'b01, 32'h0000_BEEF, 32'hBEEF_3344);
    run_store("word", 32'h0000_0300, 2'b10, 32'hDEAD_BEEF, 32'hDEAD_BEEF);
    run_store("byte0", 32'h0000_0100, 2'b00, 32'h0000_0055, 32'h1122_3355);
    run_store("byte1", 32'h0000_0101, 2'b00, 32'h0000_0066, 32'h1122_6644);
    run_store("rsvd", 32'h0000_0304, 2'b11, 32'hCAFE_F00D, 32'hCAFE_F00D);

`ifdef STORE_ALIGN_CHECK_EN
    run_misaligned("mis half", 32'h0000_0201, 2'b01, 32'h0000_BEEF);
    run_misaligned("mis word", 32'h0000_0302, 2'b10, 32'h1234_5678);
`else
    run_store("mis half", 32'h0000_0201, 2'b01, 32'h0000_BEEF, 32'h1122_BEEF);
    run_store("mis word", 32'h0000_0302, 2'b10, 32'h1234_5678, 32'h1234_5678);
`endif

    // Reset while in MERGE must abort the write.
    issue(32'h0000_0103, 2'b00, 32'h0000_00AB);
    tick();
    req_valid = 1'b0;
    tick();
    rstb = 1'b0;
    #1;
    check("abort ready", {31'b0, req_ready}, 32'd0);
    check("abort wr0", {30'b0, mem_wr_en, done}, 32'd0);
    tick();
    check("abort wr1", {30'b0, mem_wr_en, done}, 32'd0);
    check("abort addr", mem_addr, 32'd0);
    @(negedge clk);
    rstb = 1'b1;
    #1;
    check("abort ready low", {31'b0, req_ready}, 32'd0);
    tick();
    check("abort ready high", {31'b0, req_ready}, 32'd1);
    check("abort no wr", {30'b0, mem_wr_en, done}, 32'd0);

    // Back-to-back words with valid held; mid-transaction changes are ignored.
    issue(32'h0000_0400, 2'b10, 32'h0101_0101);
    tick();
    check("b2b wr1", {31'b0, mem_wr_en}, 32'd1);
    check("b2b data1", mem_wdata, 32'h0101_0101);
    req_addr  = 32'h0000_0404;
    req_wdata = 32'h0202_0202;
    tick();
    check("b2b gap", {31'b0, mem_wr_en}, 32'd0);
    check("b2b gap ready", {31'b0, req_ready}, 32'd1);
    tick();
    check("b2b wr2", {31'b0, mem_wr_en}, 32'd1);
    check("b2b data2", mem_wdata, 32'h0202_0202);
    check("b2b addr2", mem_addr, 32'h0000_0404);
    req_valid = 1'b0;
    tick();

    // Word request raised during a byte store is held off until idle.
    issue(32'h0000_0103, 2'b00, 32'h0000_0077);
    tick();
    issue(32'h0000_0600, 2'b10, 32'h9999_9999);
    check("mid rd", {31'b0, mem_rd_en}, 32'd1);
    tick();
    check("mid merge wr", {31'b0, mem_wr_en}, 32'd0);
    tick();
    check("mid wr", {31'b0, mem_wr_en}, 32'd1);
    check("mid data", mem_wdata, 32'h7722_3344);
    check("mid addr", mem_addr, 32'h0000_0100);
    tick();
    check("mid idle", {31'b0, mem_wr_en}, 32'd0);
    tick();
    check("mid next wr", {31'b0, mem_wr_en}, 32'd1);
    check("mid next data", mem_wdata, 32'h9999_9999);
    check("mid next addr", mem_addr, 32'h0000_0600);
    req_valid = 1'b0;
    tick();
    tick();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
